fp_mul_arbiter: RTL
===================

// Module: fp_mul_arbiter
// PURPOSE
//  Shares one IEEE-754 single-precision multiplier (start/valid/busy handshake) among
//  NUM_REQ requesters. Picks one pending request with round-robin priority, latches its
//  operands and pulses mul_start. It then waits for mul_valid and returns the product
//  tagged with the requester ID. Sits between the compute clients and the multiplier.
// PARAMETERS
//  NUM_REQ      4   number of requesters (2..8)
//  ID_W         2   requester ID width, = clog2(NUM_REQ)
//  TIMEOUT_CYC  64  watchdog limit in cycles; used only with FP_ARB_TIMEOUT_EN
// PORTS
//  clk          in   1           clock; all logic on rising edge
//  rst          in   1           synchronous, active-high reset
//  req_valid    in   NUM_REQ     request pending, one bit per requester
//  req_rs1      in   32*NUM_REQ  operand A; requester i on bits [32i+31:32i]
//  req_rs2      in   32*NUM_REQ  operand B; same packing as req_rs1
//  req_ready    out  NUM_REQ     one-hot accept; transfer when req_valid[i]&req_ready[i]
//  rsp_valid    out  1           one-cycle pulse: response fields are valid
//  rsp_id       out  ID_W        requester ID that owns the response
//  rsp_result   out  32          product returned by the multiplier
//  rsp_err      out  1           watchdog expired (always 0 without FP_ARB_TIMEOUT_EN)
//  mul_start    out  1           one-cycle start pulse to the multiplier
//  mul_rs1      out  32          registered operand A to the multiplier
//  mul_rs2      out  32          registered operand B to the multiplier
//  mul_result   in   32          multiplier product
//  mul_valid    in   1           multiplier result valid
//  mul_busy     in   1           multiplier busy
// BEHAVIOUR
//  Reset: state=IDLE; req_ready, mul_start, rsp_valid, rsp_err = 0.
//   mul_rs1, mul_rs2, rsp_result = 0; rsp_id = 0; rr_ptr = NUM_REQ-1 (req 0 wins first).
//   Reset in any state aborts the operation with no response. A product arriving later
//   is ignored because mul_valid is sampled only in WAIT.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: if |req_valid and !mul_busy, g = first set bit scanning rr_ptr+1 upward (wrap at
//   NUM_REQ). req_ready[g]=1 combinationally in this cycle only. Operands latch into
//   mul_rs1/mul_rs2, g latches into rsp_id, rr_ptr<=g, state->ISSUE.
//   If mul_busy=1: no grant; req_ready=0.
//  ISSUE: mul_start=1 for exactly this cycle; state->WAIT. mul_valid is ignored here.
//  WAIT: hold mul_rs1/mul_rs2 stable. On mul_valid=1: rsp_result<=mul_result, state->RESP.
//  RESP: rsp_valid=1 for one cycle with rsp_id/rsp_result; state->IDLE.
//   rsp_result and rsp_id hold until the next response.
//  Latency: accept at cycle T, mul_start at T+1, rsp_valid one cycle after mul_valid.
//   Next grant no earlier than the cycle after RESP.
//  Only one operation in flight. Requesters not granted keep req_valid and operands
//   stable. Dropping req_valid before grant withdraws the request.
//  Level-high mul_valid is tolerated: only the first WAIT-cycle sample is used.
//  The arbiter performs no arithmetic; operands and result pass through bit-exact.
// CONFIGURATION
//  FP_ARB_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT and increments each WAIT cycle.
//   - If it reaches TIMEOUT_CYC without mul_valid, go to RESP with rsp_result=32'h7FC00000
//     (qNaN) and rsp_err=1 for the same pulse.
//   - Arbitration then resumes normally.
//  FP_ARB_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; rsp_err tied 0.
// TESTING
//  1 req0: rs1=40400000, rs2=40000000 (3.0*2.0) -> one mul_start;
//    rsp_valid with id=0, result=40C00000, rsp_err=0.
//  2 req_valid=1111 held from reset -> grants in order 0,1,2,3, one req_ready pulse each,
//    never two bits high.
//  3 req0 and req2 held continuously -> grants alternate 0,2,0,2; no grant to 1 or 3.
//  4 mul_busy=1 with req_valid=0001 for 5 cycles -> req_ready=0, mul_start=0;
//    grant in the cycle mul_busy falls.
//  5 rst pulsed during WAIT, mul_valid asserted 2 cycles later -> no rsp_valid; all outputs 0;
//    next request is served normally.
//  6 (FP_ARB_TIMEOUT_EN, TIMEOUT_CYC=64) mul_valid never asserted -> rsp_valid 64 WAIT cycles
//    later, result=7FC00000, rsp_err=1.

Source files
------------

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin arbiter sharing one FP multiplier among NUM_REQ requesters
// Optional watchdog enabled by defining FP_ARB_TIMEOUT_EN.
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_rs1,
  input  logic [32*NUM_REQ-1:0] req_rs2,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_result,
  output logic                  rsp_err,
  output logic                  mul_start,
  output logic [31:0]           mul_rs1,
  output logic [31:0]           mul_rs2,
  input  logic [31:0]           mul_result,
  input  logic                  mul_valid,
  input  logic                  mul_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, gnt_idx;
  logic [31:0]     rs1_q, rs1_d, rs2_q, rs2_d, res_q, res_d;
  logic            gnt_found;
  logic            timeout_hit;
  int              scan;

  // Scan upward from the slot after the last grant, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    res_d     = res_q;
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rst && gnt_found && !mul_busy) begin
          req_ready[gnt_idx] = 1'b1;
          rs1_d   = req_rs1[32*gnt_idx +: 32];
          rs2_d   = req_rs2[32*gnt_idx +: 32];
          id_d    = gnt_idx;
          rr_d    = gnt_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (mul_valid) begin
          res_d   = mul_result;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          res_d   = 32'h7FC0_0000;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      res_q   <= res_d;
    end
  end

`ifdef FP_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q == S_WAIT) && !mul_valid && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Counter and error flag are cleared while issuing, so they start fresh on WAIT entry.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (timeout_hit) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = rsp_valid & err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
`endif

  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign mul_rs1    = rs1_q;
  assign mul_rs2    = rs2_q;

endmodule
